spi_loader: RTL and testbench
=============================

# spi_loader

Program/data loader sitting directly downstream of `spi_if` in driver mode. While the external load pin is high it holds the core in reset and repeatedly requests address+data frames from `spi_if`. Each `{data, addr}` frame it receives is written into data memory through a single-cycle write port. When loading ends it releases the core with a start pulse.

## Interface
- `DATA_W`, default `` `DATAPATH_W ``: data word width.
- `ADDR_W`, default `` `CLOG2(`DMEM_SZ) ``: memory address width.
- `clk` in 1: single clock; all logic on posedge.
- `rst` in 1: synchronous, active-high reset.
- `load_en_in` in 1: external load request, level-sensitive.
- `driver_io_out` out 1: to `spi_if.driver_io_in`; high whenever state ≠ IDLE.
- `req_out` out 1: one-cycle pulse to `spi_if.read_in`.
- `ready_in` in 1: from `spi_if.ready_out`; frame-complete strobe.
- `addr_in` in ADDR_W: from `spi_if.addr_out`.
- `data_in` in DATA_W: from `spi_if.data_out`.
- `mem_we_out` out 1: memory write enable, one cycle per word.
- `mem_addr_out` out ADDR_W: memory write address.
- `mem_data_out` out DATA_W: memory write data.
- `cpu_hold_out` out 1: holds the core in reset.
- `cpu_start_out` out 1: one-cycle pulse when the core is released.
- `word_cnt_out` out ADDR_W+1: words written in the current/last load; saturates at all-ones.
- `csum_ok_out` out 1: checksum match; used only with `LOADER_CSUM_EN`.
- `csum_err_out` out 1: checksum mismatch; used only with `LOADER_CSUM_EN`.

## Operation
- States: IDLE, REQ, WAIT, WRITE, DONE.
- IDLE:
  - All strobes are 0.
  - If `load_en_in` is high: go to REQ, clear `word_cnt`, clear the checksum accumulator, clear `csum_ok_out` and `csum_err_out`.
- REQ:
  - `req_out`=1 for exactly this cycle.
  - Go to WAIT.
- WAIT:
  - Stay until `ready_in` is high.
  - On `ready_in`, capture `addr_in`/`data_in` into holding registers and go to WRITE.
  - `load_en_in` is ignored here; an in-flight frame is never aborted.
- WRITE:
  - `mem_we_out`=1 with the held address/data.
  - `word_cnt` increments, saturating.
  - Next state is REQ if `load_en_in` is high, otherwise DONE.
- DONE:
  - `cpu_start_out`=1 for one cycle.
  - Go to IDLE.
- `cpu_hold_out` = 1 in every state except IDLE. It rises in the cycle after `load_en_in` is first seen and falls in the same cycle `cpu_start_out` is deasserted, i.e. on entering IDLE.
- `mem_addr_out`/`mem_data_out` always show the holding registers. They are valid only while `mem_we_out`=1.
- The same address written twice: the last write wins, and `word_cnt` counts both writes.
- A spurious `ready_in` in any state other than WAIT is ignored.

## Timing
- Reset values:
  - State = IDLE.
  - `driver_io_out`, `req_out`, `mem_we_out`, `cpu_hold_out`, `cpu_start_out` = 0.
  - Holding registers = 0; `word_cnt_out` = 0.
  - `csum_ok_out`, `csum_err_out` = 0; checksum accumulator = 0.
- `rst` mid-load returns to IDLE immediately and drops `cpu_hold_out` the following cycle. No `cpu_start_out` pulse is generated. `spi_if` shares `rst`, so its own transfer also aborts.
- Per-word overhead beyond the `spi_if` transfer is 3 cycles: REQ → WAIT (the frame), then WAIT → WRITE → REQ.
- `ready_in` is sampled at posedge in WAIT. `mem_we_out` is asserted on the next cycle.
- `load_en_in` dropping:
  - In REQ: the request has already been issued, so that frame is completed and written.
  - In WRITE: takes effect at the WRITE exit decision.
- `driver_io_out` is registered and is high from REQ onward. It is therefore stable before `req_out` reaches `spi_if`.

## Configuration
- `LOADER_CSUM_EN` defined:
  - A frame with `addr_in` = all-ones (2^ADDR_W−1) is a checksum frame. It is not written to memory (`mem_we_out` stays 0 in WRITE) and is not counted in `word_cnt`.
  - Its data is compared against the accumulator, which is the sum mod 2^DATA_W of all data written since the load started. Match sets `csum_ok_out`; mismatch sets `csum_err_out`.
  - Both flags are sticky until the next load start or reset.
  - If loading ends without a checksum frame, both flags stay 0.
- `LOADER_CSUM_EN` undefined:
  - Address all-ones is an ordinary memory word.
  - `csum_ok_out`/`csum_err_out` are tied 0 and there is no accumulator logic.

## Test plan
- Reset with `load_en_in`=0, then 10 idle cycles → all outputs 0 throughout; no `req_out` pulses.
- `load_en_in`=1 and three frames (addr 0/1/2, data 8'h11/8'h22/8'h33), with `load_en_in` dropped during the third WAIT → three `mem_we_out` pulses with matching addr/data; `word_cnt_out`=3; one `cpu_start_out`; `cpu_hold_out` low afterwards.
- `load_en_in` pulsed for 1 cycle only → exactly one frame requested and written, then DONE; `word_cnt_out`=1.
- `rst` asserted during WAIT → IDLE next cycle; no memory write and no `cpu_start_out`; `cpu_hold_out`=0.
- `LOADER_CSUM_EN`: data 8'hF0 and 8'h20 written, then a checksum frame (addr 4'hF, data 8'h10) → no write to 4'hF; `csum_ok_out`=1; `word_cnt_out`=2. Repeat with checksum data 8'h11 → `csum_err_out`=1.
- `ready_in` pulsed while in IDLE and in WRITE → ignored; no extra write, count unchanged.

Source files
------------

// File: rtl/spi_loader.sv
// spi_loader: pulls {data, addr} frames from spi_if while the load pin is high and writes them to data memory.
// Defining LOADER_CSUM_EN enables the checksum frame (address all-ones) and the csum_ok/csum_err flags.
`ifndef DATAPATH_W
`define DATAPATH_W 8
`endif
`ifndef DMEM_SZ
`define DMEM_SZ 16
`endif
`ifndef CLOG2
`define CLOG2(x) $clog2(x)
`endif

module spi_loader #(
    parameter int DATA_W = `DATAPATH_W,
    parameter int ADDR_W = `CLOG2(`DMEM_SZ)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_en_in,
    output logic              driver_io_out,
    output logic              req_out,
    input  logic              ready_in,
    input  logic [ADDR_W-1:0] addr_in,
    input  logic [DATA_W-1:0] data_in,
    output logic              mem_we_out,
    output logic [ADDR_W-1:0] mem_addr_out,
    output logic [DATA_W-1:0] mem_data_out,
    output logic              cpu_hold_out,
    output logic              cpu_start_out,
    output logic [ADDR_W:0]   word_cnt_out,
    output logic              csum_ok_out,
    output logic              csum_err_out
);

    // state | meaning: IDLE core runs | REQ frame requested | WAIT frame in flight | WRITE memory write | DONE start pulse
    typedef enum logic [2:0] {IDLE, REQ, WAIT, WRITE, DONE} state_t;

    state_t            state;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q;
    logic [ADDR_W:0]   word_cnt;
    logic              in_is_data;
    logic              q_is_data;

`ifdef LOADER_CSUM_EN
    localparam logic [ADDR_W-1:0] ADDR_CSUM = '1;
    logic [DATA_W-1:0] csum_acc;
    logic              csum_ok;
    logic              csum_err;

    assign in_is_data = (addr_in != ADDR_CSUM);
    assign q_is_data  = (addr_q != ADDR_CSUM);
`else
    assign in_is_data = 1'b1;
    assign q_is_data  = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            driver_io_out <= 1'b0;
            req_out       <= 1'b0;
            mem_we_out    <= 1'b0;
            cpu_hold_out  <= 1'b0;
            cpu_start_out <= 1'b0;
            addr_q        <= '0;
            data_q        <= '0;
            word_cnt      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (load_en_in) begin
                        state         <= REQ;
                        req_out       <= 1'b1;
                        driver_io_out <= 1'b1;
                        cpu_hold_out  <= 1'b1;
                        word_cnt      <= '0;
                    end
                end
                REQ: begin
                    req_out <= 1'b0;
                    state   <= WAIT;
                end
                WAIT: begin
                    // the frame already requested is always completed, whatever load_en_in does
                    if (ready_in) begin
                        addr_q     <= addr_in;
                        data_q     <= data_in;
                        mem_we_out <= in_is_data;
                        state      <= WRITE;
                    end
                end
                WRITE: begin
                    mem_we_out <= 1'b0;
                    if (q_is_data && (word_cnt != '1))
                        word_cnt <= word_cnt + 1'b1;
                    if (load_en_in) begin
                        state   <= REQ;
                        req_out <= 1'b1;
                    end else begin
                        state         <= DONE;
                        cpu_start_out <= 1'b1;
                    end
                end
                DONE: begin
                    cpu_start_out <= 1'b0;
                    driver_io_out <= 1'b0;
                    cpu_hold_out  <= 1'b0;
                    state         <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef LOADER_CSUM_EN
    // accumulator tracks data actually written; flags stay set until the next load start
    always_ff @(posedge clk) begin
        if (rst) begin
            csum_acc <= '0;
            csum_ok  <= 1'b0;
            csum_err <= 1'b0;
        end else if (state == IDLE && load_en_in) begin
            csum_acc <= '0;
            csum_ok  <= 1'b0;
            csum_err <= 1'b0;
        end else if (state == WRITE) begin
            if (q_is_data)
                csum_acc <= csum_acc + data_q;
            else if (data_q == csum_acc)
                csum_ok <= 1'b1;
            else
                csum_err <= 1'b1;
        end
    end

    assign csum_ok_out  = csum_ok;
    assign csum_err_out = csum_err;
`else
    assign csum_ok_out  = 1'b0;
    assign csum_err_out = 1'b0;
`endif

    assign mem_addr_out = addr_q;
    assign mem_data_out = data_q;
    assign word_cnt_out = word_cnt;

endmodule

// File: tb/tb_spi_loader.sv
// Bench for spi_loader: plays the spi_if side of the handshake and scoreboards memory writes.
module tb_spi_loader;
    logic       clk = 1'b0;
    logic       rst;
    logic       load_en;
    logic       ready;
    logic [3:0] addr;
    logic [7:0] data;
    logic       driver_io_out, req_out, mem_we_out, cpu_hold_out, cpu_start_out;
    logic [3:0] mem_addr_out;
    logic [7:0] mem_data_out;
    logic [4:0] word_cnt_out;
    logic       csum_ok_out, csum_err_out;

    spi_loader #(.DATA_W(8), .ADDR_W(4)) dut (
        .clk(clk), .rst(rst), .load_en_in(load_en),
        .driver_io_out(driver_io_out), .req_out(req_out), .ready_in(ready),
        .addr_in(addr), .data_in(data),
        .mem_we_out(mem_we_out), .mem_addr_out(mem_addr_out), .mem_data_out(mem_data_out),
        .cpu_hold_out(cpu_hold_out), .cpu_start_out(cpu_start_out),
        .word_cnt_out(word_cnt_out), .csum_ok_out(csum_ok_out), .csum_err_out(csum_err_out)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int n_req = 0;
    int n_start = 0;
    int n_wr = 0;
    logic [11:0] exp_q[$];
    logic [11:0] exp_wr;

    // scoreboard: every write must match the oldest frame expected to be written
    always @(negedge clk) begin
        if (req_out === 1'b1) n_req++;
        if (cpu_start_out === 1'b1) n_start++;
        if (mem_we_out === 1'b1) begin
            n_wr++;
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_write got addr=%h data=%h, expected no write", mem_addr_out, mem_data_out);
            end else begin
                exp_wr = exp_q.pop_front();
                if ({mem_addr_out, mem_data_out} !== exp_wr) begin
                    n_bad++;
                    $display("FAIL mem_write got addr=%h data=%h, expected addr=%h data=%h",
                             mem_addr_out, mem_data_out, exp_wr[11:8], exp_wr[7:0]);
                end
            end
        end
    end

    task automatic serve_frame(input logic [3:0] a, input logic [7:0] d, input bit expect_wr,
                               input bit drop_load, input int lat, input bit hold_ready);
        int k = 0;
        while (req_out !== 1'b1 && k < 50) begin
            @(negedge clk);
            k++;
        end
        n_cmp++;
        if (req_out !== 1'b1) begin
            n_bad++;
            $display("FAIL req_timeout got req_out=%b, expected 1 within 50 cycles", req_out);
            return;
        end
        @(negedge clk);
        repeat (lat) @(negedge clk);
        ready = 1'b1;
        addr  = a;
        data  = d;
        if (drop_load) load_en = 1'b0;
        if (expect_wr) exp_q.push_back({a, d});
        @(negedge clk);
        if (hold_ready) @(negedge clk);
        ready = 1'b0;
        addr  = '0;
        data  = '0;
    endtask

    task automatic wait_idle(input string name);
        int k = 0;
        while (cpu_hold_out !== 1'b0 && k < 100) begin
            @(negedge clk);
            k++;
        end
        n_cmp++;
        if (cpu_hold_out !== 1'b0) begin
            n_bad++;
            $display("FAIL %s_hold_release got cpu_hold_out=%b, expected 0", name, cpu_hold_out);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; load_en = 1'b0; ready = 1'b0; addr = '0; data = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            n_cmp++;
            if ({driver_io_out, req_out, mem_we_out, cpu_hold_out, cpu_start_out,
                 csum_ok_out, csum_err_out, mem_addr_out, mem_data_out, word_cnt_out} !== '0) begin
                n_bad++;
                $display("FAIL reset_idle got drv=%b req=%b we=%b hold=%b start=%b ok=%b err=%b a=%h d=%h cnt=%0d, expected all 0",
                         driver_io_out, req_out, mem_we_out, cpu_hold_out, cpu_start_out,
                         csum_ok_out, csum_err_out, mem_addr_out, mem_data_out, word_cnt_out);
            end
        end
        n_cmp++;
        if (n_req !== 0) begin
            n_bad++;
            $display("FAIL reset_no_req got %0d req pulses, expected 0", n_req);
        end
    endtask

    task automatic test_load3();
        int s = n_start;
        int w = n_wr;
        load_en = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({cpu_hold_out, driver_io_out, req_out} !== 3'b111) begin
            n_bad++;
            $display("FAIL load3_req_cycle got hold=%b drv=%b req=%b, expected 1 1 1", cpu_hold_out, driver_io_out, req_out);
        end
        serve_frame(4'h0, 8'h11, 1, 0, 0, 0);
        serve_frame(4'h1, 8'h22, 1, 0, 2, 0);
        serve_frame(4'h2, 8'h33, 1, 1, 1, 0);
        wait_idle("load3");
        n_cmp++;
        if (word_cnt_out !== 5'd3) begin
            n_bad++;
            $display("FAIL load3_count got %0d, expected 3", word_cnt_out);
        end
        n_cmp++;
        if (n_start - s !== 1 || n_wr - w !== 3 || exp_q.size() !== 0) begin
            n_bad++;
            $display("FAIL load3_pulses got starts=%0d writes=%0d pending=%0d, expected 1 3 0", n_start - s, n_wr - w, exp_q.size());
        end
    endtask

    task automatic test_pulse();
        int s = n_start;
        int r = n_req;
        load_en = 1'b1;
        @(negedge clk);
        load_en = 1'b0;
        serve_frame(4'h4, 8'h44, 1, 0, 0, 0);
        wait_idle("pulse");
        n_cmp++;
        if (word_cnt_out !== 5'd1 || n_start - s !== 1 || n_req - r !== 1) begin
            n_bad++;
            $display("FAIL pulse_one_frame got cnt=%0d starts=%0d reqs=%0d, expected 1 1 1", word_cnt_out, n_start - s, n_req - r);
        end
    endtask

    task automatic test_rst_wait();
        int s = n_start;
        int w = n_wr;
        load_en = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        load_en = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({cpu_hold_out, driver_io_out, req_out, mem_we_out} !== 4'b0000 || word_cnt_out !== 5'd0) begin
            n_bad++;
            $display("FAIL rst_wait_outputs got hold=%b drv=%b req=%b we=%b cnt=%0d, expected all 0",
                     cpu_hold_out, driver_io_out, req_out, mem_we_out, word_cnt_out);
        end
        rst = 1'b0;
        repeat (5) @(negedge clk);
        n_cmp++;
        if (n_start !== s || n_wr !== w || cpu_hold_out !== 1'b0) begin
            n_bad++;
            $display("FAIL rst_wait_quiet got starts=%0d writes=%0d hold=%b, expected 0 0 0", n_start - s, n_wr - w, cpu_hold_out);
        end
    endtask

    task automatic test_spurious_ready();
        int w = n_wr;
        int r = n_req;
        ready = 1'b1; addr = 4'h7; data = 8'h77;
        repeat (2) @(negedge clk);
        ready = 1'b0; addr = '0; data = '0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if (n_wr !== w || n_req !== r || cpu_hold_out !== 1'b0 || word_cnt_out !== 5'd0) begin
            n_bad++;
            $display("FAIL idle_ready_ignored got writes=%0d reqs=%0d hold=%b cnt=%0d, expected 0 0 0 0",
                     n_wr - w, n_req - r, cpu_hold_out, word_cnt_out);
        end
        load_en = 1'b1;
        serve_frame(4'h5, 8'h55, 1, 0, 0, 1);
        serve_frame(4'h6, 8'h66, 1, 1, 0, 0);
        wait_idle("spurious");
        n_cmp++;
        if (word_cnt_out !== 5'd2 || n_wr - w !== 2) begin
            n_bad++;
            $display("FAIL write_ready_ignored got cnt=%0d writes=%0d, expected 2 2", word_cnt_out, n_wr - w);
        end
    endtask

    task automatic test_back_to_back();
        int s = n_start;
        int w = n_wr;
        load_en = 1'b1;
        serve_frame(4'h3, 8'hAA, 1, 0, 0, 0);
        serve_frame(4'h3, 8'hBB, 1, 1, 0, 0);
        wait_idle("same_addr");
        n_cmp++;
        if (word_cnt_out !== 5'd2) begin
            n_bad++;
            $display("FAIL same_addr_count got %0d, expected 2", word_cnt_out);
        end
        load_en = 1'b1;
        serve_frame(4'h8, 8'h5A, 1, 1, 0, 0);
        wait_idle("back_to_back");
        n_cmp++;
        if (word_cnt_out !== 5'd1 || n_start - s !== 2 || n_wr - w !== 3) begin
            n_bad++;
            $display("FAIL back_to_back got cnt=%0d starts=%0d writes=%0d, expected 1 2 3", word_cnt_out, n_start - s, n_wr - w);
        end
    endtask

    task automatic test_csum();
`ifdef LOADER_CSUM_EN
        load_en = 1'b1;
        serve_frame(4'h0, 8'hF0, 1, 0, 0, 0);
        serve_frame(4'h1, 8'h20, 1, 0, 0, 0);
        serve_frame(4'hF, 8'h10, 0, 1, 0, 0);
        wait_idle("csum_ok");
        n_cmp++;
        if ({csum_ok_out, csum_err_out} !== 2'b10 || word_cnt_out !== 5'd2) begin
            n_bad++;
            $display("FAIL csum_match got ok=%b err=%b cnt=%0d, expected 1 0 2", csum_ok_out, csum_err_out, word_cnt_out);
        end
        load_en = 1'b1;
        serve_frame(4'h0, 8'hF0, 1, 0, 0, 0);
        serve_frame(4'h1, 8'h20, 1, 0, 0, 0);
        serve_frame(4'hF, 8'h11, 0, 1, 0, 0);
        wait_idle("csum_err");
        n_cmp++;
        if ({csum_ok_out, csum_err_out} !== 2'b01 || word_cnt_out !== 5'd2) begin
            n_bad++;
            $display("FAIL csum_mismatch got ok=%b err=%b cnt=%0d, expected 0 1 2", csum_ok_out, csum_err_out, word_cnt_out);
        end
`else
        load_en = 1'b1;
        serve_frame(4'hF, 8'hAB, 1, 1, 0, 0);
        wait_idle("addr_ones");
        n_cmp++;
        if ({csum_ok_out, csum_err_out} !== 2'b00 || word_cnt_out !== 5'd1) begin
            n_bad++;
            $display("FAIL addr_ones_plain got ok=%b err=%b cnt=%0d, expected 0 0 1", csum_ok_out, csum_err_out, word_cnt_out);
        end
`endif
    endtask

    task automatic test_saturate();
        load_en = 1'b1;
        for (int i = 0; i < 33; i++)
            serve_frame(4'(i % 15), 8'(i * 3 + 1), 1, i == 32, 0, 0);
        wait_idle("saturate");
        n_cmp++;
        if (word_cnt_out !== 5'd31 || exp_q.size() !== 0) begin
            n_bad++;
            $display("FAIL saturate_count got cnt=%0d pending=%0d, expected 31 0", word_cnt_out, exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_load3();
        test_pulse();
        test_rst_wait();
        test_spurious_ready();
        test_back_to_back();
        test_csum();
        test_saturate();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL global_timeout got no finish, expected finish before 400000");
        $fatal(1, "timeout");
    end
endmodule
